// File: rtl/mealy_ring_fsm.sv
// Parametrised ring sequencer with Mealy output, minimum-dwell guard and wrap/error flags.
// Out and out_valid respond in the same cycle as the command; state follows one edge later.
module mealy_ring_fsm #(
    parameter int unsigned NUM_STATES  = 4,
    parameter int unsigned OUT_WIDTH   = 2,
    parameter int unsigned MIN_DWELL   = 0,
    parameter int unsigned RESET_STATE = 1,
    localparam int unsigned STATE_WIDTH = (NUM_STATES <= 2) ? 1 : $clog2(NUM_STATES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [1:0]             cmd,
    input  logic [STATE_WIDTH-1:0] jump_target,
    output logic [OUT_WIDTH-1:0]   out,
    output logic                   out_valid,
    output logic [STATE_WIDTH-1:0] state,
    output logic                   wrap,
    output logic                   err
);

    typedef enum logic [1:0] {
        CmdHold = 2'd0,
        CmdNext = 2'd1,
        CmdPrev = 2'd2,
        CmdJump = 2'd3
    } cmd_e;

    localparam logic [STATE_WIDTH-1:0] LAST_STATE = STATE_WIDTH'(NUM_STATES - 1);
    localparam logic [STATE_WIDTH-1:0] RESET_IDX  = STATE_WIDTH'(RESET_STATE);
    localparam logic [STATE_WIDTH:0]   NUM_EXT    = (STATE_WIDTH + 1)'(NUM_STATES);
    localparam logic [7:0]             DWELL_MAX  = 8'(MIN_DWELL);

    logic [STATE_WIDTH-1:0] r_state;
    logic [OUT_WIDTH-1:0]   r_out;
    logic [7:0]             r_dwell;

    logic                   w_jump_ok;
    logic                   w_dwell_ok;
    logic                   w_accept;
    logic [STATE_WIDTH-1:0] w_dest;
    logic [STATE_WIDTH:0]   w_dest_p1;
    logic [OUT_WIDTH-1:0]   w_out_acc;

    // Widen by one bit so NUM_STATES == 2^STATE_WIDTH still compares correctly.
    assign w_jump_ok  = ({1'b0, jump_target} < NUM_EXT);
    assign w_dwell_ok = (r_dwell >= DWELL_MAX);

    always_comb begin
        w_dest = r_state;
        unique case (cmd)
            CmdNext: w_dest = (r_state == LAST_STATE) ? '0 : r_state + STATE_WIDTH'(1);
            CmdPrev: w_dest = (r_state == '0) ? LAST_STATE : r_state - STATE_WIDTH'(1);
            CmdJump: w_dest = jump_target;
            default: w_dest = r_state;
        endcase
    end

    assign w_dest_p1 = {1'b0, w_dest} + (STATE_WIDTH + 1)'(1);
    assign w_out_acc = OUT_WIDTH'(w_dest_p1);

    always_comb begin
        w_accept = rst && en && (cmd != CmdHold) && w_dwell_ok
                   && ((cmd != CmdJump) || w_jump_ok);
        out_valid = w_accept;
        out       = '0;
        if (rst) begin
            out = w_accept ? w_out_acc : r_out;
        end
        wrap = w_accept && (((cmd == CmdNext) && (r_state == LAST_STATE))
                         || ((cmd == CmdPrev) && (r_state == '0)));
        // Flagged regardless of dwell so a bad target is never silently swallowed.
        err  = rst && en && (cmd == CmdJump) && !w_jump_ok;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= RESET_IDX;
            r_out   <= '0;
            r_dwell <= '0;
        end else if (w_accept) begin
            r_state <= w_dest;
            r_out   <= w_out_acc;
            r_dwell <= '0;
        end else if (r_dwell < DWELL_MAX) begin
            r_dwell <= r_dwell + 8'd1;
        end
    end

    assign state = r_state;

endmodule

// File: tb/tb_mealy_ring_fsm.sv
// Bench for mealy_ring_fsm: four parameterisations driven by directed and random commands,
// each checked against an integer ring model.
module tb_mealy_ring_fsm;

    localparam int N_C  [4] = '{5, 2, 5, 16};
    localparam int OW_C [4] = '{3, 2, 3, 8};
    localparam int MD_C [4] = '{3, 0, 0, 1};
    localparam int RS_C [4] = '{1, 1, 4, 0};
    localparam int SW_C [4] = '{3, 1, 3, 4};

    logic            clk;
    logic            rst;
    logic [3:0]      en_v;
    logic [3:0][1:0] cmd_v;
    logic [3:0][3:0] jt_v;

    logic [2:0] out0;
    logic [1:0] out1;
    logic [2:0] out2;
    logic [7:0] out3;
    logic [2:0] st0;
    logic [0:0] st1;
    logic [2:0] st2;
    logic [3:0] st3;
    logic [3:0] vld_v;
    logic [3:0] wrap_v;
    logic [3:0] err_v;

    logic [3:0][7:0] a_out;
    logic [3:0][3:0] a_st;

    assign a_out[0] = 8'(out0);
    assign a_out[1] = 8'(out1);
    assign a_out[2] = 8'(out2);
    assign a_out[3] = out3;
    assign a_st[0]  = 4'(st0);
    assign a_st[1]  = 4'(st1);
    assign a_st[2]  = 4'(st2);
    assign a_st[3]  = st3;

    mealy_ring_fsm #(.NUM_STATES(5), .OUT_WIDTH(3), .MIN_DWELL(3), .RESET_STATE(1)) u_dut0 (
        .clk(clk), .rst(rst), .en(en_v[0]), .cmd(cmd_v[0]), .jump_target(jt_v[0][2:0]),
        .out(out0), .out_valid(vld_v[0]), .state(st0), .wrap(wrap_v[0]), .err(err_v[0])
    );
    mealy_ring_fsm #(.NUM_STATES(2), .OUT_WIDTH(2), .MIN_DWELL(0), .RESET_STATE(1)) u_dut1 (
        .clk(clk), .rst(rst), .en(en_v[1]), .cmd(cmd_v[1]), .jump_target(jt_v[1][0:0]),
        .out(out1), .out_valid(vld_v[1]), .state(st1), .wrap(wrap_v[1]), .err(err_v[1])
    );
    mealy_ring_fsm #(.NUM_STATES(5), .OUT_WIDTH(3), .MIN_DWELL(0), .RESET_STATE(4)) u_dut2 (
        .clk(clk), .rst(rst), .en(en_v[2]), .cmd(cmd_v[2]), .jump_target(jt_v[2][2:0]),
        .out(out2), .out_valid(vld_v[2]), .state(st2), .wrap(wrap_v[2]), .err(err_v[2])
    );
    mealy_ring_fsm #(.NUM_STATES(16), .OUT_WIDTH(8), .MIN_DWELL(1), .RESET_STATE(0)) u_dut3 (
        .clk(clk), .rst(rst), .en(en_v[3]), .cmd(cmd_v[3]), .jump_target(jt_v[3]),
        .out(out3), .out_valid(vld_v[3]), .state(st3), .wrap(wrap_v[3]), .err(err_v[3])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int m_st [4];
    int m_dw [4];
    int m_oq [4];
    int n_tests;
    int n_fail;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_st[k] = RS_C[k];
            m_dw[k] = 0;
            m_oq[k] = 0;
        end
    endtask

    function automatic void model_eval(input int k, output bit acc, output int dest,
                                       output int eo, output bit ew, output bit ee);
        int  n  = N_C[k];
        int  c  = int'(cmd_v[k]);
        int  jt = int'(jt_v[k]);
        bit  e  = en_v[k];
        bit  bad_jump = (c == 3) && (jt >= n);
        ee  = rst && e && bad_jump;
        acc = rst && e && (c != 0) && (m_dw[k] >= MD_C[k]) && !bad_jump;
        case (c)
            1:       dest = (m_st[k] + 1) % n;
            2:       dest = (m_st[k] + n - 1) % n;
            3:       dest = jt;
            default: dest = m_st[k];
        endcase
        eo = acc ? (dest + 1) % (1 << OW_C[k]) : (rst ? m_oq[k] : 0);
        ew = acc && (((c == 1) && (m_st[k] == n - 1)) || ((c == 2) && (m_st[k] == 0)));
    endfunction

    task automatic model_tick();
        bit acc, ew, ee;
        int dest, eo;
        for (int k = 0; k < 4; k++) begin
            model_eval(k, acc, dest, eo, ew, ee);
            if (acc) begin
                m_st[k] = dest;
                m_oq[k] = eo;
                m_dw[k] = 0;
            end else if (m_dw[k] < MD_C[k]) begin
                m_dw[k]++;
            end
        end
    endtask

    task automatic check_all();
        bit acc, ew, ee;
        int dest, eo;
        for (int k = 0; k < 4; k++) begin
            model_eval(k, acc, dest, eo, ew, ee);
            check_val($sformatf("out%0d", k),   32'(a_out[k]),  32'(eo));
            check_val($sformatf("valid%0d", k), 32'(vld_v[k]),  32'(acc));
            check_val($sformatf("wrap%0d", k),  32'(wrap_v[k]), 32'(ew));
            check_val($sformatf("err%0d", k),   32'(err_v[k]),  32'(ee));
            check_val($sformatf("state%0d", k), 32'(a_st[k]),   32'(m_st[k]));
        end
    endtask

    // Called at a falling edge with inputs already applied; returns at the next falling edge.
    task automatic step();
        #1 check_all();
        @(posedge clk);
        if (rst) model_tick();
        @(negedge clk);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b0;
        en_v    = '0;
        cmd_v   = '0;
        jt_v    = '0;
        model_reset();

        #12;
        check_all();
        check_val("rst_state1", 32'(st1), 32'd1);
        check_val("rst_out1", 32'(out1), 32'd0);
        en_v  = 4'hf;
        cmd_v = {4{2'd1}};
        #1 check_all();

        @(negedge clk);
        rst   = 1'b1;
        en_v  = '0;
        cmd_v = '0;

        // Two-state ring
        en_v[1] = 1'b1; cmd_v[1] = 2'd1;
        #1;
        check_val("d1_next_valid", 32'(vld_v[1]), 32'd1);
        check_val("d1_next_out", 32'(out1), 32'd1);
        check_val("d1_next_wrap", 32'(wrap_v[1]), 32'd1);
        step();
        check_val("d1_next_state", 32'(st1), 32'd0);
        cmd_v[1] = 2'd3; jt_v[1] = 4'd1;
        #1 check_val("d1_jump_out", 32'(out1), 32'd2);
        step();
        #1;
        check_val("d1_self_out", 32'(out1), 32'd2);
        check_val("d1_self_valid", 32'(vld_v[1]), 32'd1);
        step();
        en_v[1] = 1'b0;

        // Five-state ring starting at 4
        en_v[2] = 1'b1; cmd_v[2] = 2'd1;
        #1;
        check_val("d2_next_wrap", 32'(wrap_v[2]), 32'd1);
        check_val("d2_next_out", 32'(out2), 32'd1);
        step();
        check_val("d2_next_state", 32'(st2), 32'd0);
        cmd_v[2] = 2'd2;
        #1;
        check_val("d2_prev_wrap", 32'(wrap_v[2]), 32'd1);
        check_val("d2_prev_out", 32'(out2), 32'd5);
        step();
        check_val("d2_prev_state", 32'(st2), 32'd4);
        cmd_v[2] = 2'd3; jt_v[2] = 4'd6;
        #1;
        check_val("d2_bad_err", 32'(err_v[2]), 32'd1);
        check_val("d2_bad_valid", 32'(vld_v[2]), 32'd0);
        check_val("d2_bad_out", 32'(out2), 32'd5);
        step();
        check_val("d2_bad_state", 32'(st2), 32'd4);
        en_v[2] = 1'b0;
        #1 check_val("d2_bad_en0_err", 32'(err_v[2]), 32'd0);
        jt_v[2] = '0; cmd_v[2] = '0;

        // Dwell guard: idle with en=0, then back-to-back NEXT
        cmd_v[0] = 2'd1;
        for (int i = 0; i < 10; i++) step();
        check_val("d0_idle_state", 32'(st0), 32'd1);
        en_v[0] = 1'b1;
        #1;
        check_val("d0_first_valid", 32'(vld_v[0]), 32'd1);
        check_val("d0_first_out", 32'(out0), 32'd3);
        step();
        for (int i = 1; i <= 3; i++) begin
            #1;
            check_val($sformatf("d0_dwell%0d_valid", i), 32'(vld_v[0]), 32'd0);
            check_val($sformatf("d0_dwell%0d_out", i), 32'(out0), 32'd3);
            step();
        end
        #1;
        check_val("d0_after_valid", 32'(vld_v[0]), 32'd1);
        check_val("d0_after_out", 32'(out0), 32'd4);
        step();
        en_v[0] = 1'b0;

        // Asynchronous reset from state 3
        en_v[3] = 1'b1; cmd_v[3] = 2'd3; jt_v[3] = 4'd3;
        step();
        check_val("d3_jump_state", 32'(st3), 32'd3);
        en_v[3] = 1'b0;
        #2 rst = 1'b0;
        model_reset();
        #1;
        check_val("d3_arst_state", 32'(st3), 32'd0);
        check_val("d3_arst_out", 32'(out3), 32'd0);
        check_all();
        @(negedge clk);
        rst = 1'b1;
        en_v[1] = 1'b1; cmd_v[1] = 2'd1;
        #1 check_val("d1_post_rst_out", 32'(out1), 32'd1);
        step();

        // Random phase
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst = 1'b1;
            for (int k = 0; k < 4; k++) begin
                en_v[k]  = ($urandom_range(0, 3) != 0);
                cmd_v[k] = 2'($urandom_range(0, 3));
                jt_v[k]  = 4'($urandom_range(0, (1 << SW_C[k]) - 1));
            end
            if ($urandom_range(0, 149) == 0) begin
                #2 rst = 1'b0;
                model_reset();
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
